// File: rtl/dram_arb_if.sv
// Bundle of request/response/RAM signals between the two requesters, the arbiter and the single-port RAM.
// The arbiter takes the slave modport; requesters and the RAM model take the master modport.
interface dram_arb_if #(
    parameter int XLEN = 32
);
    logic            cpu_req_i;
    logic            cpu_wr_i;
    logic [XLEN-1:0] cpu_addr_i;
    logic [XLEN-1:0] cpu_wr_data_i;
    logic [3:0]      cpu_byte_en_i;
    logic            cpu_gnt_o;
    logic            cpu_rd_vld_o;
    logic [XLEN-1:0] cpu_rd_data_o;

    logic            host_req_i;
    logic            host_wr_i;
    logic [XLEN-1:0] host_addr_i;
    logic [XLEN-1:0] host_wr_data_i;
    logic            host_gnt_o;
    logic            host_rd_vld_o;
    logic [XLEN-1:0] host_rd_data_o;

    logic            ram_en_o;
    logic            ram_wr_en_o;
    logic [3:0]      ram_byte_en_o;
    logic [XLEN-1:0] ram_addr_o;
    logic [XLEN-1:0] ram_wr_data_o;
    logic [XLEN-1:0] ram_rd_data_i;

    modport slave (
        input  cpu_req_i, cpu_wr_i, cpu_addr_i, cpu_wr_data_i, cpu_byte_en_i,
        output cpu_gnt_o, cpu_rd_vld_o, cpu_rd_data_o,
        input  host_req_i, host_wr_i, host_addr_i, host_wr_data_i,
        output host_gnt_o, host_rd_vld_o, host_rd_data_o,
        output ram_en_o, ram_wr_en_o, ram_byte_en_o, ram_addr_o, ram_wr_data_o,
        input  ram_rd_data_i
    );

    modport master (
        output cpu_req_i, cpu_wr_i, cpu_addr_i, cpu_wr_data_i, cpu_byte_en_i,
        input  cpu_gnt_o, cpu_rd_vld_o, cpu_rd_data_o,
        output host_req_i, host_wr_i, host_addr_i, host_wr_data_i,
        input  host_gnt_o, host_rd_vld_o, host_rd_data_o,
        input  ram_en_o, ram_wr_en_o, ram_byte_en_o, ram_addr_o, ram_wr_data_o,
        output ram_rd_data_i
    );
endinterface

// File: rtl/dram_arb.sv
// Two-requester (CPU / SPI host) arbiter in front of a single-port RAM, one access per cycle.
// Define RAM_ARB_FAIR_EN to compile in host starvation protection (forced host grant after STARVE_MAX waits).
module dram_arb #(
    parameter int XLEN       = 32,
    parameter int STARVE_MAX = 8
) (
    input logic       clk_i,
    input logic       rst_n_i,
    dram_arb_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        CPU_RD,
        HOST_RD
    } owner_t;

    owner_t          owner_s1;
    owner_t          owner_s2;
    logic            cpu_gnt;
    logic            host_gnt;
    logic            force_host;
    logic            ram_en_q;
    logic            ram_wr_en_q;
    logic [3:0]      ram_byte_en_q;
    logic [XLEN-1:0] ram_addr_q;
    logic [XLEN-1:0] ram_wr_data_q;

    // Grants are gated by reset so every output reads 0 while rst_n_i is low.
    assign cpu_gnt  = rst_n_i && bus.cpu_req_i && !force_host;
    assign host_gnt = rst_n_i && bus.host_req_i && !cpu_gnt;

`ifdef RAM_ARB_FAIR_EN
    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    logic [CW-1:0] starve_cnt;

    assign force_host = bus.host_req_i && (starve_cnt == STARVE_LIM);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            starve_cnt <= '0;
        end else if (!bus.host_req_i || host_gnt) begin
            starve_cnt <= '0;
        end else if (starve_cnt != STARVE_LIM) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`else
    assign force_host = 1'b0;
`endif

    // Stage 1 tracks the command on the RAM pins, stage 2 the cycle its read data is valid.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            owner_s1      <= IDLE;
            owner_s2      <= IDLE;
            ram_en_q      <= 1'b0;
            ram_wr_en_q   <= 1'b0;
            ram_byte_en_q <= '0;
            ram_addr_q    <= '0;
            ram_wr_data_q <= '0;
        end else begin
            owner_s2 <= owner_s1;
            if (cpu_gnt) begin
                owner_s1      <= bus.cpu_wr_i ? IDLE : CPU_RD;
                ram_en_q      <= 1'b1;
                ram_wr_en_q   <= bus.cpu_wr_i;
                ram_byte_en_q <= bus.cpu_byte_en_i;
                ram_addr_q    <= bus.cpu_addr_i;
                ram_wr_data_q <= bus.cpu_wr_data_i;
            end else if (host_gnt) begin
                owner_s1      <= bus.host_wr_i ? IDLE : HOST_RD;
                ram_en_q      <= 1'b1;
                ram_wr_en_q   <= bus.host_wr_i;
                ram_byte_en_q <= 4'hF;
                ram_addr_q    <= bus.host_addr_i;
                ram_wr_data_q <= bus.host_wr_data_i;
            end else begin
                owner_s1    <= IDLE;
                ram_en_q    <= 1'b0;
                ram_wr_en_q <= 1'b0;
            end
        end
    end

    assign bus.cpu_gnt_o      = cpu_gnt;
    assign bus.host_gnt_o     = host_gnt;
    assign bus.cpu_rd_vld_o   = (owner_s2 == CPU_RD);
    assign bus.host_rd_vld_o  = (owner_s2 == HOST_RD);
    assign bus.cpu_rd_data_o  = (owner_s2 == CPU_RD)  ? bus.ram_rd_data_i : '0;
    assign bus.host_rd_data_o = (owner_s2 == HOST_RD) ? bus.ram_rd_data_i : '0;

    assign bus.ram_en_o      = ram_en_q;
    assign bus.ram_wr_en_o   = ram_wr_en_q;
    assign bus.ram_byte_en_o = ram_byte_en_q;
    assign bus.ram_addr_o    = ram_addr_q;
    assign bus.ram_wr_data_o = ram_wr_data_q;

endmodule

// File: tb/tb_dram_arb.sv
// Directed bench for dram_arb: reset, single-source reads/writes, alternating owners, contention, mid-read reset.
// A small word-addressed RAM model answers reads one cycle after the command and applies byte-enabled writes.
module tb_dram_arb;

    logic clk;
    logic rst_n;
    int   check_cnt;
    int   pass_cnt;
    int   fail_cnt;

    logic [31:0] mem [0:15];

    dram_arb_if #(.XLEN(32)) bus ();

    dram_arb #(
        .XLEN      (32),
        .STARVE_MAX(8)
    ) dut (
        .clk_i  (clk),
        .rst_n_i(rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: registered read data, byte-enabled writes.
    always @(posedge clk) begin
        if (bus.ram_en_o && !bus.ram_wr_en_o) begin
            bus.ram_rd_data_i <= mem[bus.ram_addr_o[5:2]];
        end
        if (bus.ram_en_o && bus.ram_wr_en_o) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.ram_byte_en_o[b]) begin
                    mem[bus.ram_addr_o[5:2]][b*8 +: 8] <= bus.ram_wr_data_o[b*8 +: 8];
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(
        input logic        c_req,
        input logic        c_wr,
        input logic [31:0] c_addr,
        input logic [31:0] c_data,
        input logic [3:0]  c_be,
        input logic        h_req,
        input logic        h_wr,
        input logic [31:0] h_addr,
        input logic [31:0] h_data
    );
        bus.cpu_req_i      = c_req;
        bus.cpu_wr_i       = c_wr;
        bus.cpu_addr_i     = c_addr;
        bus.cpu_wr_data_i  = c_data;
        bus.cpu_byte_en_i  = c_be;
        bus.host_req_i     = h_req;
        bus.host_wr_i      = h_wr;
        bus.host_addr_i    = h_addr;
        bus.host_wr_data_i = h_data;
    endtask

    task automatic apply_idle();
        apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_cnt++;
        assert (observed === expected) pass_cnt++;
        else begin
            fail_cnt++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

`ifdef RAM_ARB_FAIR_EN
    localparam int CONT_CYCLES = 17;
`else
    localparam int CONT_CYCLES = 20;
`endif

    initial begin
        check_cnt = 0;
        pass_cnt  = 0;
        fail_cnt  = 0;
        for (int i = 0; i < 16; i++) mem[i] <= 32'hC0DE_0000 | 32'(i);
        mem[4] <= 32'hDEAD_BEEF;
        mem[8] <= 32'hFFFF_FFFF;
        bus.ram_rd_data_i <= 32'h0;

        // Reset asserted with a CPU read already pending
        rst_n = 1'b0;
        apply_stimulus(1'b1, 1'b0, 32'h0, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0, 32'h0);
        #2;
        check_output("rst_cpu_gnt", {31'b0, bus.cpu_gnt_o}, 32'h0);
        check_output("rst_host_gnt", {31'b0, bus.host_gnt_o}, 32'h0);
        check_output("rst_ram_en", {31'b0, bus.ram_en_o}, 32'h0);
        check_output("rst_ram_addr", bus.ram_addr_o, 32'h0);
        check_output("rst_cpu_rd_vld", {31'b0, bus.cpu_rd_vld_o}, 32'h0);
        step();
        rst_n = 1'b1;
        #1;
        check_output("rel_cpu_gnt", {31'b0, bus.cpu_gnt_o}, 32'h1);
        step();
        check_output("rel_ram_en", {31'b0, bus.ram_en_o}, 32'h1);
        check_output("rel_ram_wr_en", {31'b0, bus.ram_wr_en_o}, 32'h0);
        check_output("rel_ram_be", {28'b0, bus.ram_byte_en_o}, 32'hF);
        apply_idle();
        step();
        check_output("rel_cpu_rd_vld", {31'b0, bus.cpu_rd_vld_o}, 32'h1);
        check_output("rel_cpu_rd_data", bus.cpu_rd_data_o, 32'hC0DE_0000);
        check_output("rel_host_rd_vld", {31'b0, bus.host_rd_vld_o}, 32'h0);
        check_output("idle_ram_en", {31'b0, bus.ram_en_o}, 32'h0);
        step();
        check_output("idle_cpu_rd_vld", {31'b0, bus.cpu_rd_vld_o}, 32'h0);
        check_output("idle_cpu_rd_data", bus.cpu_rd_data_o, 32'h0);

        // Host read alone at 0x10
        apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h10, 32'h0);
        #1;
        check_output("hrd_host_gnt", {31'b0, bus.host_gnt_o}, 32'h1);
        check_output("hrd_cpu_gnt", {31'b0, bus.cpu_gnt_o}, 32'h0);
        step();
        check_output("hrd_ram_en", {31'b0, bus.ram_en_o}, 32'h1);
        check_output("hrd_ram_wr_en", {31'b0, bus.ram_wr_en_o}, 32'h0);
        check_output("hrd_ram_addr", bus.ram_addr_o, 32'h10);
        check_output("hrd_ram_be", {28'b0, bus.ram_byte_en_o}, 32'hF);
        apply_idle();
        step();
        check_output("hrd_host_rd_vld", {31'b0, bus.host_rd_vld_o}, 32'h1);
        check_output("hrd_host_rd_data", bus.host_rd_data_o, 32'hDEAD_BEEF);
        check_output("hrd_cpu_rd_vld", {31'b0, bus.cpu_rd_vld_o}, 32'h0);
        check_output("hrd_cpu_rd_data", bus.cpu_rd_data_o, 32'h0);

        // CPU partial write to 0x20
        apply_stimulus(1'b1, 1'b1, 32'h20, 32'h1234_5678, 4'b0011, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check_output("cwr_cpu_gnt", {31'b0, bus.cpu_gnt_o}, 32'h1);
        step();
        check_output("cwr_ram_en", {31'b0, bus.ram_en_o}, 32'h1);
        check_output("cwr_ram_wr_en", {31'b0, bus.ram_wr_en_o}, 32'h1);
        check_output("cwr_ram_be", {28'b0, bus.ram_byte_en_o}, 32'h3);
        check_output("cwr_ram_addr", bus.ram_addr_o, 32'h20);
        check_output("cwr_ram_wdata", bus.ram_wr_data_o, 32'h1234_5678);
        apply_idle();
        step();
        check_output("cwr_cpu_rd_vld", {31'b0, bus.cpu_rd_vld_o}, 32'h0);
        check_output("cwr_host_rd_vld", {31'b0, bus.host_rd_vld_o}, 32'h0);
        check_output("hold_ram_wr_en", {31'b0, bus.ram_wr_en_o}, 32'h0);
        check_output("hold_ram_be", {28'b0, bus.ram_byte_en_o}, 32'h3);
        check_output("hold_ram_addr", bus.ram_addr_o, 32'h20);
        check_output("hold_ram_wdata", bus.ram_wr_data_o, 32'h1234_5678);

        // Host reads back the partially written word
        apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h20, 32'h0);
        step();
        check_output("rb_ram_be", {28'b0, bus.ram_byte_en_o}, 32'hF);
        apply_idle();
        step();
        check_output("rb_host_rd_data", bus.host_rd_data_o, 32'hFFFF_5678);

        // Alternating CPU 0x0 / host 0x4 reads
        apply_stimulus(1'b1, 1'b0, 32'h0, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check_output("alt_cpu_gnt", {31'b0, bus.cpu_gnt_o}, 32'h1);
        step();
        apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h4, 32'h0);
        #1;
        check_output("alt_host_gnt", {31'b0, bus.host_gnt_o}, 32'h1);
        step();
        check_output("alt1_cpu_rd_vld", {31'b0, bus.cpu_rd_vld_o}, 32'h1);
        check_output("alt1_cpu_rd_data", bus.cpu_rd_data_o, 32'hC0DE_0000);
        check_output("alt1_host_rd_vld", {31'b0, bus.host_rd_vld_o}, 32'h0);
        apply_stimulus(1'b1, 1'b0, 32'h0, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        check_output("alt2_host_rd_vld", {31'b0, bus.host_rd_vld_o}, 32'h1);
        check_output("alt2_host_rd_data", bus.host_rd_data_o, 32'hC0DE_0001);
        check_output("alt2_cpu_rd_vld", {31'b0, bus.cpu_rd_vld_o}, 32'h0);
        apply_idle();
        step();
        check_output("alt3_cpu_rd_vld", {31'b0, bus.cpu_rd_vld_o}, 32'h1);
        check_output("alt3_cpu_rd_data", bus.cpu_rd_data_o, 32'hC0DE_0000);
        check_output("alt3_host_rd_vld", {31'b0, bus.host_rd_vld_o}, 32'h0);
        step();
        check_output("alt4_cpu_rd_vld", {31'b0, bus.cpu_rd_vld_o}, 32'h0);
        check_output("alt4_host_rd_vld", {31'b0, bus.host_rd_vld_o}, 32'h0);

        // Both requesters held high
        apply_stimulus(1'b1, 1'b0, 32'h0, 32'h0, 4'hF, 1'b1, 1'b0, 32'h4, 32'h0);
        #1;
        for (int i = 0; i < CONT_CYCLES; i++) begin
`ifdef RAM_ARB_FAIR_EN
            check_output($sformatf("cont%0d_cpu_gnt", i + 1), {31'b0, bus.cpu_gnt_o}, (i == 8) ? 32'h0 : 32'h1);
            check_output($sformatf("cont%0d_host_gnt", i + 1), {31'b0, bus.host_gnt_o}, (i == 8) ? 32'h1 : 32'h0);
`else
            check_output($sformatf("cont%0d_cpu_gnt", i + 1), {31'b0, bus.cpu_gnt_o}, 32'h1);
            check_output($sformatf("cont%0d_host_gnt", i + 1), {31'b0, bus.host_gnt_o}, 32'h0);
`endif
            step();
        end
        apply_idle();
        step();
        step();
        step();

        // Reset between grant and read-valid of a CPU read
        apply_stimulus(1'b1, 1'b0, 32'h4, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        check_output("mid_ram_en_pre", {31'b0, bus.ram_en_o}, 32'h1);
        apply_idle();
        #2;
        rst_n = 1'b0;
        #1;
        check_output("mid_ram_en", {31'b0, bus.ram_en_o}, 32'h0);
        check_output("mid_ram_addr", bus.ram_addr_o, 32'h0);
        check_output("mid_cpu_rd_vld", {31'b0, bus.cpu_rd_vld_o}, 32'h0);
        check_output("mid_cpu_rd_data", bus.cpu_rd_data_o, 32'h0);
        step();
        rst_n = 1'b1;
        step();
        check_output("post1_cpu_rd_vld", {31'b0, bus.cpu_rd_vld_o}, 32'h0);
        step();
        check_output("post2_cpu_rd_vld", {31'b0, bus.cpu_rd_vld_o}, 32'h0);
        check_output("post2_host_rd_vld", {31'b0, bus.host_rd_vld_o}, 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
